// File: rtl/mbist_ctl.sv
// March C- BIST sequencer for the shared XRAM/IRAM behind the memory peripheral bus.
// Drives the bus BIST override and checks read data one cycle later, capturing the first failure.
module mbist_ctl #(
    parameter logic [10:0] XA_LO   = 11'h000,
    parameter logic [10:0] XA_HI   = 11'h4FF,
    parameter logic [10:0] IA_LO   = 11'h500,
    parameter logic [10:0] IA_HI   = 11'h5FF,
    parameter bit          IRAM_EN = 1'b1,
    parameter logic [7:0]  PAT     = 8'h00
) (
    input  logic        mclk,
    input  logic        srstz,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  iram_rdat,
    input  logic [7:0]  xram_rdat,
    output logic        bist_en,
    output logic        bist_wr,
    output logic [10:0] bist_adr,
    output logic [7:0]  bist_wdat,
    output logic        bist_xram,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [7:0]  fail_cnt,
    output logic [10:0] fail_adr,
    output logic        fail_xram,
    output logic [7:0]  fail_rdat,
    output logic [7:0]  fail_exp
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  elem, elem_nxt;
    logic        op, op_nxt;
    logic [10:0] adr_nxt;
    logic        xram_nxt;
    logic        en_nxt, wr_nxt;
    logic [7:0]  wdat_nxt;
    logic        start_acc, active;
    logic [10:0] lo, hi;
    logic        down, last_op, at_end;
    logic [7:0]  exp_cur;
    logic        rd_pend, rd_xram;
    logic [10:0] rd_adr;
    logic [7:0]  rd_exp, rdat;

    assign busy      = bist_en;
    assign active    = (state == RUN) || (state == FLUSH);
    assign start_acc = (state == IDLE || state == DONE) && start && !abort;
    assign lo        = bist_xram ? XA_LO : IA_LO;
    assign hi        = bist_xram ? XA_HI : IA_HI;
    assign down      = (elem == 3'd3) || (elem == 3'd4);
    // M1..M4 are read-then-write pairs; M0 and M5 are single ops
    assign last_op   = (elem == 3'd0) || (elem == 3'd5) || op;
    assign at_end    = down ? (bist_adr == lo) : (bist_adr == hi);
    assign exp_cur   = (elem == 3'd2 || elem == 3'd4) ? ~PAT : PAT;
    assign rdat      = rd_xram ? xram_rdat : iram_rdat;

    always_ff @(posedge mclk or negedge srstz) begin
        if (!srstz) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        op_nxt    = op;
        adr_nxt   = bist_adr;
        xram_nxt  = bist_xram;
        case (state)
            IDLE, DONE: if (start_acc) begin
                state_nxt = RUN;
                elem_nxt  = 3'd0;
                op_nxt    = 1'b0;
                adr_nxt   = XA_LO;
                xram_nxt  = 1'b1;
            end
            RUN: if (abort) begin
                state_nxt = IDLE;
            end else if (!last_op) begin
                op_nxt = 1'b1;
            end else if (!at_end) begin
                op_nxt  = 1'b0;
                adr_nxt = down ? bist_adr - 11'd1 : bist_adr + 11'd1;
            end else if (elem != 3'd5) begin
                elem_nxt = elem + 3'd1;
                op_nxt   = 1'b0;
                adr_nxt  = (elem == 3'd2 || elem == 3'd3) ? hi : lo;
            end else if (bist_xram && IRAM_EN) begin
                elem_nxt = 3'd0;
                op_nxt   = 1'b0;
                adr_nxt  = IA_LO;
                xram_nxt = 1'b0;
            end else begin
                state_nxt = FLUSH;
            end
            FLUSH: state_nxt = abort ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        en_nxt   = (state_nxt == RUN) || (state_nxt == FLUSH);
        wr_nxt   = (state_nxt == RUN) &&
                   ((elem_nxt == 3'd0) || (elem_nxt != 3'd5 && op_nxt));
        wdat_nxt = bist_wdat;
        if (wr_nxt) wdat_nxt = (elem_nxt == 3'd1 || elem_nxt == 3'd3) ? ~PAT : PAT;
    end

    always_ff @(posedge mclk or negedge srstz) begin
        if (!srstz) begin
            elem      <= 3'd0;
            op        <= 1'b0;
            bist_en   <= 1'b0;
            bist_wr   <= 1'b0;
            bist_adr  <= '0;
            bist_wdat <= '0;
            bist_xram <= 1'b0;
            done      <= 1'b0;
            rd_pend   <= 1'b0;
            rd_xram   <= 1'b0;
            rd_adr    <= '0;
            rd_exp    <= '0;
            fail      <= 1'b0;
            fail_cnt  <= '0;
            fail_adr  <= '0;
            fail_xram <= 1'b0;
            fail_rdat <= '0;
            fail_exp  <= '0;
        end else begin
            elem      <= elem_nxt;
            op        <= op_nxt;
            bist_en   <= en_nxt;
            bist_wr   <= wr_nxt;
            bist_adr  <= adr_nxt;
            bist_wdat <= wdat_nxt;
            bist_xram <= xram_nxt;
            done      <= (state_nxt == DONE);
            rd_pend   <= (state == RUN) && !abort && !bist_wr;
            rd_xram   <= bist_xram;
            rd_adr    <= bist_adr;
            rd_exp    <= exp_cur;
            if (start_acc) begin
                fail      <= 1'b0;
                fail_cnt  <= '0;
                fail_adr  <= '0;
                fail_xram <= 1'b0;
                fail_rdat <= '0;
                fail_exp  <= '0;
            end else if (rd_pend && !(active && abort) && rdat != rd_exp) begin
                if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_adr  <= rd_adr;
                    fail_xram <= rd_xram;
                    fail_rdat <= rdat;
                    fail_exp  <= rd_exp;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbist_ctl.sv
// Directed bench for mbist_ctl: two instances (IRAM phase on / off) over small behavioural SRAMs
// with optional stuck-at faults.
module tb_mbist_ctl;

    logic mclk = 1'b0;
    logic srstz = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic flt_x = 1'b0;   // XRAM adr 2 bit0 stuck-at-1
    logic flt_i = 1'b0;   // IRAM adr 11 stuck at 8'h00
    int   total = 0;
    int   bad = 0;

    always #5 mclk = ~mclk;

    logic        a_en, a_wr, a_xram, a_busy, a_done, a_fail, a_fxram;
    logic [10:0] a_adr, a_fadr;
    logic [7:0]  a_wdat, a_fcnt, a_frdat, a_fexp, a_ir, a_xr;
    logic        b_en, b_wr, b_xram, b_busy, b_done, b_fail, b_fxram;
    logic [10:0] b_adr, b_fadr;
    logic [7:0]  b_wdat, b_fcnt, b_frdat, b_fexp, b_ir, b_xr;

    logic [7:0] xmem_a [16];
    logic [7:0] imem_a [16];
    logic [7:0] xmem_b [16];
    logic [7:0] imem_b [16];

    mbist_ctl #(.XA_LO(11'd0), .XA_HI(11'd3), .IA_LO(11'd8), .IA_HI(11'd11),
                .IRAM_EN(1'b1), .PAT(8'h00)) u_dut_a (
        .mclk(mclk), .srstz(srstz), .start(start), .abort(abort),
        .iram_rdat(a_ir), .xram_rdat(a_xr),
        .bist_en(a_en), .bist_wr(a_wr), .bist_adr(a_adr), .bist_wdat(a_wdat),
        .bist_xram(a_xram), .busy(a_busy), .done(a_done), .fail(a_fail),
        .fail_cnt(a_fcnt), .fail_adr(a_fadr), .fail_xram(a_fxram),
        .fail_rdat(a_frdat), .fail_exp(a_fexp));

    mbist_ctl #(.XA_LO(11'd0), .XA_HI(11'd3), .IA_LO(11'd8), .IA_HI(11'd11),
                .IRAM_EN(1'b0), .PAT(8'h00)) u_dut_b (
        .mclk(mclk), .srstz(srstz), .start(start), .abort(abort),
        .iram_rdat(b_ir), .xram_rdat(b_xr),
        .bist_en(b_en), .bist_wr(b_wr), .bist_adr(b_adr), .bist_wdat(b_wdat),
        .bist_xram(b_xram), .busy(b_busy), .done(b_done), .fail(b_fail),
        .fail_cnt(b_fcnt), .fail_adr(b_fadr), .fail_xram(b_fxram),
        .fail_rdat(b_frdat), .fail_exp(b_fexp));

    // synchronous-read SRAM models, faults applied on the read path
    always @(posedge mclk) begin
        if (a_en && a_wr && a_xram)  xmem_a[a_adr[3:0]] <= a_wdat;
        if (a_en && a_wr && !a_xram) imem_a[a_adr[3:0]] <= a_wdat;
        if (a_en && !a_wr && a_xram)
            a_xr <= xmem_a[a_adr[3:0]] | {7'd0, flt_x && a_adr == 11'd2};
        if (a_en && !a_wr && !a_xram)
            a_ir <= (flt_i && a_adr == 11'd11) ? 8'h00 : imem_a[a_adr[3:0]];
        if (b_en && b_wr && b_xram)  xmem_b[b_adr[3:0]] <= b_wdat;
        if (b_en && b_wr && !b_xram) imem_b[b_adr[3:0]] <= b_wdat;
        if (b_en && !b_wr && b_xram)  b_xr <= xmem_b[b_adr[3:0]];
        if (b_en && !b_wr && !b_xram) b_ir <= imem_b[b_adr[3:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_a();
        return {3'd0, a_en, a_wr, a_adr, a_wdat, a_xram, a_busy, a_done, a_fail,
                a_fcnt, a_fadr, a_fxram, a_frdat, a_fexp};
    endfunction

    // start pulse, then sample each cycle on the falling edge until both instances are done
    task automatic run(input int budget, input bit trace,
                       output int na, output int nb, output bit b_left_x);
        na = 0; nb = 0; b_left_x = 1'b0;
        @(negedge mclk) start = 1'b1;
        @(negedge mclk) start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (cyc > 1) @(negedge mclk);
            if (a_en) na++;
            if (b_en) nb++;
            if (b_en && !b_xram) b_left_x = 1'b1;
            if (cyc == 1)
                check("first_op", {a_en, a_busy, a_done, a_xram, a_wr, a_adr},
                      {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 11'd0});
            if (trace && cyc <= 4)
                check("m0_write", {a_wr, a_adr, a_wdat}, {1'b1, 11'(cyc - 1), 8'h00});
            if (trace && cyc == 5)
                check("m1_read", {a_wr, a_adr}, {1'b0, 11'd0});
            if (trace && cyc == 6)
                check("m1_write", {a_wr, a_adr, a_wdat}, {1'b1, 11'd0, 8'hFF});
            if (trace && cyc == 40)
                check("x_last", {a_xram, a_wr, a_adr}, {1'b1, 1'b0, 11'd3});
            if (trace && cyc == 41)
                check("i_first", {a_xram, a_wr, a_adr, a_wdat}, {1'b0, 1'b1, 11'd8, 8'h00});
            if (trace && cyc == 41)
                check("b_flush", {b_en, b_wr}, {1'b1, 1'b0});
            if (a_done && b_done) break;
        end
        check("run_done", {a_done, b_done}, 2'b11);
    endtask

    int  na, nb;
    bit  lx;

    initial begin
        repeat (3) @(negedge mclk);
        check("reset_a", outs_a(), 64'd0);
        srstz = 1'b1;
        @(negedge mclk);
        check("idle_a", outs_a(), 64'd0);

        // fault-free, both instances
        run(200, 1'b1, na, nb, lx);
        check("en_cycles_a", na, 81);
        check("status_a", {a_done, a_fail, a_fcnt}, {1'b1, 1'b0, 8'd0});
        check("en_cycles_b", nb, 41);
        check("b_xram_held", lx, 0);
        check("status_b", {b_done, b_fail, b_fcnt}, {1'b1, 1'b0, 8'd0});
        repeat (3) @(negedge mclk);
        check("done_held", {a_done, a_en}, 2'b10);

        // XRAM adr 2 bit0 stuck-at-1
        flt_x = 1'b1;
        run(200, 1'b0, na, nb, lx);
        check("xflt_first", {a_fail, a_fadr, a_fxram, a_frdat, a_fexp},
              {1'b1, 11'd2, 1'b1, 8'h01, 8'h00});
        check("xflt_cnt", a_fcnt, 8'd3);
        check("xflt_done", a_done, 1'b1);
        flt_x = 1'b0;

        // IRAM adr 11 stuck at 00
        flt_i = 1'b1;
        run(200, 1'b0, na, nb, lx);
        check("iflt_first", {a_fail, a_fadr, a_fxram, a_frdat, a_fexp},
              {1'b1, 11'd11, 1'b0, 8'h00, 8'hFF});
        check("iflt_cnt", a_fcnt, 8'd2);
        flt_i = 1'b0;

        // abort on cycle 10, then restart from IDLE
        @(negedge mclk) start = 1'b1;
        @(negedge mclk) start = 1'b0;
        check("restart_clears", {a_fail, a_fcnt, a_fadr}, '0);
        repeat (9) @(negedge mclk);
        check("pre_abort", {a_en, a_adr}, {1'b1, 11'd2});
        abort = 1'b1;
        @(negedge mclk) abort = 1'b0;
        check("aborted", {a_en, a_busy, a_done, b_en, b_done}, 5'b00000);
        @(negedge mclk);
        check("abort_idle", {a_en, a_done}, 2'b00);
        run(200, 1'b0, na, nb, lx);
        check("post_abort", {na, 7'd0, a_fail, a_fcnt}, {32'd81, 7'd0, 1'b0, 8'd0});

        // reset mid-run with a fault active
        flt_x = 1'b1;
        @(negedge mclk) start = 1'b1;
        @(negedge mclk) start = 1'b0;
        repeat (28) @(negedge mclk);
        check("pre_reset_fail", {a_en, a_fail}, 2'b11);
        srstz = 1'b0;
        #1;
        check("midrun_reset", outs_a(), 64'd0);
        @(negedge mclk) srstz = 1'b1;
        flt_x = 1'b0;
        run(200, 1'b0, na, nb, lx);
        check("clean_rerun", {na, 6'd0, a_done, a_fail, a_fcnt}, {32'd81, 6'd0, 1'b1, 1'b0, 8'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
